// File: rtl/shift_rotate.sv
// Registered 1-bit shift/rotate unit: SLL, SRL, SRA, ROL, ROR, SLA; reserved opcodes pass through.
// Latency 1 cycle, throughput 1 op/clock.
// No backpressure: a new operand/opcode pair is accepted every clock.
module shift_rotate #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100,
    OP_SLA = 3'b101
  } op_e;

  logic [WIDTH-1:0] sll_val;
  logic [WIDTH-1:0] r;

  assign sll_val = {a[WIDTH-2:0], 1'b0};

  always_comb begin
    r = a;
    case (opcode)
      OP_SLL:  r = sll_val;
      OP_SRL:  r = {1'b0, a[WIDTH-1:1]};
      OP_SRA:  r = {a[WIDTH-1], a[WIDTH-1:1]};
      OP_ROL:  r = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  r = {a[0], a[WIDTH-1:1]};
      // Sign bit kept; taking the shifted value's low bits also covers WIDTH=2.
      OP_SLA:  r = {a[WIDTH-1], sll_val[WIDTH-2:0]};
      default: r = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else begin
      result <= r;
    end
  end

endmodule

// File: tb/tb_shift_rotate.sv
// Self-checking bench for shift_rotate (WIDTH=8) against an arithmetic reference model.
module tb_shift_rotate;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [2:0] opcode;
  logic [7:0] result;

  int n_cmp;
  int n_err;

  shift_rotate #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .opcode (opcode),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written with plain integer arithmetic on the operand value.
  function automatic logic [7:0] model(input int av, input int op);
    int sign;
    int v;
    sign = (av >= 128) ? 128 : 0;
    case (op)
      0: v = (av * 2) % 256;
      1: v = av / 2;
      2: v = av / 2 + sign;
      3: v = (av * 2) % 256 + av / 128;
      4: v = av / 2 + (av % 2) * 128;
      5: v = sign + (av * 2) % 128;
      default: v = av;
    endcase
    return v[7:0];
  endfunction

  // Drive inputs mid-cycle, then let one rising edge sample them.
  task automatic apply(input logic [7:0] av, input logic [2:0] op);
    @(negedge clk);
    a      = av;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply($urandom_range(255), $urandom_range(7));
      n_cmp++;
      if (result !== 8'h00) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, result, 8'h00);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    apply(8'b10110101, 3'b000);
    n_cmp++;
    if (result !== 8'b01101010) begin
      n_err++;
      $display("FAIL reset_release: got %b expected %b", result, 8'b01101010);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [12];
    logic [2:0] to [12];
    logic [7:0] te [12];
    ta = '{8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'h34, 8'hB5, 8'hB5, 8'hB5, 8'h40, 8'h80, 8'h7F};
    to = '{3'd0,  3'd1,  3'd2,  3'd3,  3'd4,  3'd2,  3'd5,  3'd6,  3'd7,  3'd5,  3'd5,  3'd5};
    te = '{8'b01101010, 8'b01011010, 8'b11011010, 8'b01101011, 8'b11011010, 8'b00011010,
           8'b11101010, 8'b10110101, 8'b10110101, 8'b00000000, 8'b10000000, 8'b01111110};
    for (int i = 0; i < 12; i++) begin
      apply(ta[i], to[i]);
      n_cmp++;
      if (result !== te[i]) begin
        n_err++;
        $display("FAIL directed[%0d] a=%b op=%0d: got %b expected %b", i, ta[i], to[i], result, te[i]);
      end
    end
  endtask

  task automatic test_edge_operands();
    logic [7:0] ones_exp [8];
    ones_exp = '{8'hFE, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'hFF};
    for (int op = 0; op < 8; op++) begin
      apply(8'h00, op[2:0]);
      n_cmp++;
      if (result !== 8'h00) begin
        n_err++;
        $display("FAIL edge_zero op=%0d: got %b expected %b", op, result, 8'h00);
      end
      apply(8'hFF, op[2:0]);
      n_cmp++;
      if (result !== ones_exp[op]) begin
        n_err++;
        $display("FAIL edge_ones op=%0d: got %b expected %b", op, result, ones_exp[op]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq_exp [6];
    logic [7:0] prev;
    seq_exp = '{8'b01101010, 8'b01011010, 8'b11011010, 8'b01101011, 8'b11011010, 8'b11101010};
    apply(8'h00, 3'd7);
    prev = 8'h00;
    for (int op = 0; op < 6; op++) begin
      @(negedge clk);
      // Before the sampling edge the previous result must still be visible.
      n_cmp++;
      if (result !== prev) begin
        n_err++;
        $display("FAIL b2b_lag op=%0d: got %b expected %b", op, result, prev);
      end
      a      = 8'b10110101;
      opcode = op[2:0];
      @(posedge clk);
      #1;
      n_cmp++;
      if (result !== seq_exp[op]) begin
        n_err++;
        $display("FAIL b2b op=%0d: got %b expected %b", op, result, seq_exp[op]);
      end
      prev = seq_exp[op];
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] av;
    logic [2:0] op;
    apply(8'hB5, 3'd3);
    @(negedge clk);
    rst    = 1'b1;
    a      = 8'h5A;
    opcode = 3'd0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (result !== 8'h00) begin
      n_err++;
      $display("FAIL midstream_reset: got %b expected %b", result, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    av  = 8'h3C;
    op  = 3'd4;
    apply(av, op);
    n_cmp++;
    if (result !== model(av, op)) begin
      n_err++;
      $display("FAIL midstream_resume: got %b expected %b", result, model(av, op));
    end
  endtask

  task automatic test_random();
    logic [7:0] av;
    logic [2:0] op;
    logic [7:0] exp_v;
    for (int i = 0; i < 300; i++) begin
      av    = 8'($urandom_range(255));
      op    = 3'($urandom_range(7));
      exp_v = model(av, op);
      apply(av, op);
      n_cmp++;
      if (result !== exp_v) begin
        n_err++;
        $display("FAIL random[%0d] a=%b op=%0d: got %b expected %b", i, av, op, result, exp_v);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    a      = 8'h00;
    opcode = 3'd0;
    test_reset();
    test_directed();
    test_edge_operands();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
